avg_pool2x_stream: RTL and testbench
====================================

# avg_pool2x_stream

Streaming 2x2 stride-2 average-pooling downscaler for raster video (e.g. 1920x1080 to 960x540). Parametrised in component width, channel count and maximum line width. Accepts one pixel per valid cycle in raster order with frame and line markers. Buffers horizontal pair sums of each even row in an internal line buffer and emits one averaged pixel per 2x2 block on the odd row. Sits in the ZOOM path between the capture/raster source and the frame writer; no backpressure, matching HDMI pixel flow.

## Interface
- DATA_W, 8, bits per colour component
- CH, 3, components per pixel, packed with channel 0 in the LSBs
- MAX_W, 1920, maximum input line width in pixels; must be even
- clk  input  1  pixel clock; all logic on its rising edge
- rst  input  1  synchronous, active-high reset
- i_valid  input  1  input pixel present this cycle
- i_sof  input  1  first pixel of frame; qualified by i_valid
- i_eol  input  1  last pixel of line; qualified by i_valid
- i_data  input  CH*DATA_W  input pixel
- o_valid  output  1  output pixel present this cycle
- o_sof  output  1  first output pixel of frame; qualified by o_valid
- o_eol  output  1  last output pixel of line; qualified by o_valid
- o_data  output  CH*DATA_W  averaged pixel
- o_err  output  1  sticky framing error flag

## Operation
- Row state machine:
  - WAIT_SOF: reset state; pixels are ignored until i_valid&i_sof.
  - EVEN_ROW: row 0, 2, 4, ... of the frame.
  - ODD_ROW: row 1, 3, 5, ...
- Transitions:
  - Accepted i_sof: col=0, enter EVEN_ROW; that pixel is col 0 of row 0. This applies from any state, including mid-line. A partial block in progress is discarded.
  - Accepted i_eol: EVEN_ROW->ODD_ROW, ODD_ROW->EVEN_ROW, col=0.
- Column phase: even column latches the pixel; odd column forms per-channel pair sum p = a + b, DATA_W+1 bits.
- EVEN_ROW, odd column: write p to line buffer at address col>>1. Depth MAX_W/2, width CH*(DATA_W+1), sync read/write, single clock.
- ODD_ROW:
  - Even column: issue line-buffer read at col>>1.
  - Odd column: s = p + buf, DATA_W+2 bits per channel; result = s>>2, which never overflows.
- o_sof: first output of the frame (row 1, col 1).
- o_eol: output produced by an odd-column pixel carrying i_eol.
- Errors:
  - col beyond MAX_W-1: buffer write suppressed, no output, o_err set.
  - i_eol on an even column (odd width): unpaired pixel dropped, o_err set.
  - o_err clears only on rst.
- Odd frame height: the last row is buffered and never emitted; not an error.

## Timing
- Reset values: o_valid=0, o_sof=0, o_eol=0, o_data=0, o_err=0; state WAIT_SOF, col=0. Line buffer contents are don't-care.
- Latency: o_valid is high exactly 1 cycle after the accepted odd-column pixel of an ODD_ROW.
- Outputs are registered and held between valid pulses. o_valid, o_sof and o_eol are single-cycle pulses.
- Input gaps (i_valid=0) of any length are allowed anywhere. The line-buffer read data register holds across gaps.
- Back-to-back input gives one output every 2 cycles on odd rows and none on even rows.
- rst mid-frame: next cycle all outputs are 0 and the state is WAIT_SOF. Any in-flight output is dropped.
- i_sof and i_eol on the same pixel: a 1-pixel line. This is an odd width, so o_err is set and the state becomes ODD_ROW.

## Configuration
- AVGPOOL_ROUND_EN defined: result = (s + 2) >> 2, round half up. (4*max+2)>>2 = max, so no saturation logic is needed.
- AVGPOOL_ROUND_EN undefined: result = s >> 2, truncation.

## Test plan
- 4x2 frame, 1 channel, DATA_W=8. Row0 10,20,30,40; row1 50,60,70,82; back-to-back input.
  - Outputs 35 then 55 (truncation) or 35 then 56 (AVGPOOL_ROUND_EN).
  - o_sof on the first output, o_eol on the second, each 1 cycle after the odd-column input.
- All channels at 255 over a 1920x1080 frame: 960x540 outputs, all 255. Exactly 540 o_eol pulses and 1 o_sof.
- Same 4x2 frame with random 0-5 cycle i_valid gaps: identical output values and markers; latency still 1 cycle after each odd-row odd-column pixel.
- 5-pixel-wide line: o_err rises on the i_eol pixel and stays high. 2 outputs per odd row. rst clears o_err to 0.
- rst asserted during row 1 of a frame: outputs 0 the next cycle. Pixels without i_sof produce nothing. A following clean 4x2 frame gives 35, 55.
- 4x3 frame: 2 outputs only; row 2 produces none; o_err stays 0.

Source files
------------

// File: rtl/avg_pool2x_stream.sv
// Streaming 2x2 stride-2 average-pooling downscaler for raster video.
// Define AVGPOOL_ROUND_EN for round-half-up averaging; truncation otherwise.
module avg_pool2x_stream #(
   parameter int DATA_W = 8,
   parameter int CH     = 3,
   parameter int MAX_W  = 1920
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_valid,
   input  logic                 i_sof,
   input  logic                 i_eol,
   input  logic [CH*DATA_W-1:0] i_data,
   output logic                 o_valid,
   output logic                 o_sof,
   output logic                 o_eol,
   output logic [CH*DATA_W-1:0] o_data,
   output logic                 o_err
);

   localparam int DEPTH = MAX_W / 2;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW    = $clog2(MAX_W + 1);
   localparam int PW    = DATA_W + 1;
   localparam int BW    = CH * PW;

   typedef enum logic [1:0] {
      WAIT_SOF = 2'd0,
      EVEN_ROW = 2'd1,
      ODD_ROW  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   state_t               st_eff;
   logic [CW-1:0]        col_q, col_d, col_eff;
   logic [CH*DATA_W-1:0] a_q, a_d;
   logic                 first_q, first_d, first_eff;
   logic                 err_q, err_d;
   logic                 o_valid_q, o_valid_d;
   logic                 o_sof_q, o_sof_d;
   logic                 o_eol_q, o_eol_d;
   logic [CH*DATA_W-1:0] o_data_q, o_data_d;

   logic [BW-1:0]        pair_sum;
   logic [BW-1:0]        rd_data_q;
   logic [CH*DATA_W-1:0] avg;
   logic                 wr_en, rd_en;
   logic [AW-1:0]        buf_addr;

   logic [BW-1:0]        line_mem [DEPTH];

   // Per-channel arithmetic: horizontal pair sum, then vertical sum with the buffered row.
   genvar gi;
   generate
      for (gi = 0; gi < CH; gi++) begin : g_ch
         logic [PW-1:0]     p;
         logic [DATA_W+1:0] s;
         assign p = {1'b0, a_q[gi*DATA_W +: DATA_W]} + {1'b0, i_data[gi*DATA_W +: DATA_W]};
         assign s = {1'b0, p} + {1'b0, rd_data_q[gi*PW +: PW]};
         assign pair_sum[gi*PW +: PW] = p;
`ifdef AVGPOOL_ROUND_EN
         assign avg[gi*DATA_W +: DATA_W] = DATA_W'((s + (DATA_W+2)'(2)) >> 2);
`else
         assign avg[gi*DATA_W +: DATA_W] = DATA_W'(s >> 2);
`endif
      end
   endgenerate

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      a_d       = a_q;
      first_d   = first_q;
      err_d     = err_q;
      o_valid_d = 1'b0;
      o_sof_d   = 1'b0;
      o_eol_d   = 1'b0;
      o_data_d  = o_data_q;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      st_eff    = state_q;
      col_eff   = col_q;
      first_eff = first_q;

      // A start-of-frame pixel resynchronises from any state, dropping any partial block.
      if (i_valid && i_sof) begin
         st_eff    = EVEN_ROW;
         col_eff   = '0;
         first_eff = 1'b1;
      end

      buf_addr = AW'(col_eff >> 1);

      if (i_valid && st_eff != WAIT_SOF) begin
         if (col_eff >= CW'(MAX_W)) begin
            err_d = 1'b1;
         end else if (!col_eff[0]) begin
            a_d   = i_data;
            rd_en = (st_eff == ODD_ROW);
            if (i_eol) begin
               err_d = 1'b1;
            end
         end else if (st_eff == EVEN_ROW) begin
            wr_en = 1'b1;
         end else begin
            o_valid_d = 1'b1;
            o_sof_d   = first_eff;
            o_eol_d   = i_eol;
            o_data_d  = avg;
            first_eff = 1'b0;
         end

         if (i_eol) begin
            state_d = (st_eff == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
            col_d   = '0;
         end else begin
            state_d = st_eff;
            // Saturate so an overlong line keeps flagging instead of wrapping.
            col_d   = (col_eff >= CW'(MAX_W)) ? CW'(MAX_W) : col_eff + CW'(1);
         end
         first_d = first_eff;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= WAIT_SOF;
         col_q     <= '0;
         a_q       <= '0;
         first_q   <= 1'b0;
         err_q     <= 1'b0;
         o_valid_q <= 1'b0;
         o_sof_q   <= 1'b0;
         o_eol_q   <= 1'b0;
         o_data_q  <= '0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         a_q       <= a_d;
         first_q   <= first_d;
         err_q     <= err_d;
         o_valid_q <= o_valid_d;
         o_sof_q   <= o_sof_d;
         o_eol_q   <= o_eol_d;
         o_data_q  <= o_data_d;
      end
   end

   // Line buffer: contents need no reset; the read register holds across input gaps.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         line_mem[buf_addr] <= pair_sum;
      end
      if (rd_en) begin
         rd_data_q <= line_mem[buf_addr];
      end
   end

   assign o_valid = o_valid_q;
   assign o_sof   = o_sof_q;
   assign o_eol   = o_eol_q;
   assign o_data  = o_data_q;
   assign o_err   = err_q;

endmodule

// File: tb/tb_avg_pool2x_stream.sv
// Self-checking bench for avg_pool2x_stream: scoreboard of expected pooled pixels with
// per-output latency checks, plus per-cycle checks of the sticky error flag.
module tb_avg_pool2x_stream;

   localparam int DATA_W = 8;
   localparam int CH     = 3;
   localparam int MAX_W  = 16;
   localparam int PXW    = CH * DATA_W;
   localparam int NEVER  = 32'h7fffffff;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           i_valid = 1'b0;
   logic           i_sof = 1'b0;
   logic           i_eol = 1'b0;
   logic [PXW-1:0] i_data = '0;
   logic           o_valid, o_sof, o_eol, o_err;
   logic [PXW-1:0] o_data;

   avg_pool2x_stream #(.DATA_W(DATA_W), .CH(CH), .MAX_W(MAX_W)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_sof(i_sof), .i_eol(i_eol),
      .i_data(i_data), .o_valid(o_valid), .o_sof(o_sof), .o_eol(o_eol),
      .o_data(o_data), .o_err(o_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total_cnt = 0;
   int pass_cnt  = 0;
   int out_cnt   = 0;
   int sof_cnt   = 0;
   int eol_cnt   = 0;
   bit sb_en     = 1'b1;
   int err_due   = NEVER;

   logic [PXW+1:0] exp_q [$];
   int             due_q [$];
   logic [PXW-1:0] img [0:11][0:19];

`ifdef AVGPOOL_ROUND_EN
   localparam logic [7:0] SECOND_CH0 = 8'd56;
`else
   localparam logic [7:0] SECOND_CH0 = 8'd55;
`endif

   function automatic logic [PXW-1:0] blk(input int r, input int c);
      logic [PXW-1:0] res;
      int sum;
      res = '0;
      for (int ch = 0; ch < CH; ch++) begin
         sum = int'(img[r-1][c-1][ch*DATA_W +: DATA_W]) + int'(img[r-1][c][ch*DATA_W +: DATA_W])
             + int'(img[r][c-1][ch*DATA_W +: DATA_W])   + int'(img[r][c][ch*DATA_W +: DATA_W]);
`ifdef AVGPOOL_ROUND_EN
         sum = sum + 2;
`endif
         res[ch*DATA_W +: DATA_W] = DATA_W'(sum >> 2);
      end
      return res;
   endfunction

   // Output monitor: scoreboard pops, latency, pulse shape and sticky error flag.
   always @(negedge clk) begin
      if (!rst) begin
         total_cnt++;
         if (o_err !== (cyc >= err_due))
            $display("FAIL o_err cyc=%0d: got %b want %b", cyc, o_err, (cyc >= err_due));
         else
            pass_cnt++;
         if (o_valid) begin
            out_cnt++;
            if (o_sof) sof_cnt++;
            if (o_eol) eol_cnt++;
            if (sb_en) begin
               total_cnt++;
               if (exp_q.size() == 0) begin
                  $display("FAIL unexpected_out cyc=%0d: got data %h, want no output", cyc, o_data);
               end else begin
                  logic [PXW+1:0] e;
                  int d;
                  e = exp_q.pop_front();
                  d = due_q.pop_front();
                  if ({o_sof, o_eol, o_data} !== e || cyc != d)
                     $display("FAIL out_pixel: got sof=%b eol=%b data=%h cyc=%0d, want sof=%b eol=%b data=%h cyc=%0d",
                              o_sof, o_eol, o_data, cyc, e[PXW+1], e[PXW], e[PXW-1:0], d);
                  else begin
                     pass_cnt++;
                     $display("out cyc=%0d sof=%b eol=%b data=%h", cyc, o_sof, o_eol, o_data);
                  end
               end
            end
         end else begin
            total_cnt++;
            if (o_sof !== 1'b0 || o_eol !== 1'b0)
               $display("FAIL marker_without_valid cyc=%0d: got sof=%b eol=%b want 0 0", cyc, o_sof, o_eol);
            else
               pass_cnt++;
            if (sb_en && due_q.size() > 0 && due_q[0] < cyc) begin
               total_cnt++;
               $display("FAIL missed_out: got no output by cyc=%0d, want data %h at cyc=%0d",
                        cyc, exp_q[0][PXW-1:0], due_q[0]);
               void'(exp_q.pop_front());
               void'(due_q.pop_front());
            end
         end
      end
   end

   task automatic send_frame(input int w, input int h, input int maxgap, input bit with_sof, input int npix);
      int n;
      bit first;
      n = 0;
      first = with_sof;
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            if (npix < 0 || n < npix) begin
               int gap;
               gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
               repeat (gap) begin
                  @(posedge clk); #1;
                  i_valid = 1'b0;
               end
               @(posedge clk); #1;
               i_valid = 1'b1;
               i_sof   = with_sof && r == 0 && c == 0;
               i_eol   = (c == w - 1);
               i_data  = img[r][c];
               if ((c >= MAX_W || (i_eol && c % 2 == 0)) && err_due == NEVER)
                  err_due = cyc + 1;
               if (with_sof && r % 2 == 1 && c % 2 == 1 && c < MAX_W) begin
                  exp_q.push_back({first, i_eol, blk(r, c)});
                  due_q.push_back(cyc + 1);
                  first = 1'b0;
               end
               n++;
            end
         end
      end
      @(posedge clk); #1;
      i_valid = 1'b0;
      i_sof   = 1'b0;
      i_eol   = 1'b0;
   endtask

   task automatic drain();
      repeat (4) @(posedge clk);
      @(negedge clk);
      total_cnt++;
      if (exp_q.size() != 0)
         $display("FAIL drain: got %0d pending outputs, want 0", exp_q.size());
      else
         pass_cnt++;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      i_valid = 1'b0;
      exp_q.delete();
      due_q.delete();
      err_due = NEVER;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic fill_basic();
      logic [7:0] v [0:7];
      v = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd82};
      for (int i = 0; i < 8; i++)
         img[i/4][i%4] = {8'(255 - v[i]), 8'(v[i] * 3), v[i]};
   endtask

   task automatic fill_random();
      for (int r = 0; r < 12; r++)
         for (int c = 0; c < 20; c++)
            img[r][c] = PXW'($urandom);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      total_cnt += 5;
      if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", o_valid); else pass_cnt++;
      if (o_sof !== 1'b0)   $display("FAIL reset_sof: got %b want 0", o_sof);     else pass_cnt++;
      if (o_eol !== 1'b0)   $display("FAIL reset_eol: got %b want 0", o_eol);     else pass_cnt++;
      if (o_data !== '0)    $display("FAIL reset_data: got %h want 0", o_data);   else pass_cnt++;
      if (o_err !== 1'b0)   $display("FAIL reset_err: got %b want 0", o_err);     else pass_cnt++;
   endtask

   task automatic test_basic();
      fill_basic();
      out_cnt = 0;
      send_frame(4, 2, 0, 1'b1, -1);
      drain();
      total_cnt += 2;
      if (out_cnt != 2) $display("FAIL basic_count: got %0d want 2", out_cnt); else pass_cnt++;
      if (o_data[7:0] !== SECOND_CH0)
         $display("FAIL basic_held_ch0: got %0d want %0d", o_data[7:0], SECOND_CH0);
      else pass_cnt++;
   endtask

   task automatic test_all_max();
      for (int r = 0; r < 12; r++)
         for (int c = 0; c < 20; c++)
            img[r][c] = '1;
      out_cnt = 0; sof_cnt = 0; eol_cnt = 0;
      send_frame(MAX_W, 10, 0, 1'b1, -1);
      drain();
      total_cnt += 4;
      if (out_cnt != 40) $display("FAIL max_count: got %0d want 40", out_cnt); else pass_cnt++;
      if (eol_cnt != 5)  $display("FAIL max_eol: got %0d want 5", eol_cnt);    else pass_cnt++;
      if (sof_cnt != 1)  $display("FAIL max_sof: got %0d want 1", sof_cnt);    else pass_cnt++;
      if (o_data !== '1) $display("FAIL max_data: got %h want all ones", o_data); else pass_cnt++;
   endtask

   task automatic test_gaps();
      fill_basic();
      out_cnt = 0;
      send_frame(4, 2, 5, 1'b1, -1);
      drain();
      total_cnt++;
      if (out_cnt != 2) $display("FAIL gaps_count: got %0d want 2", out_cnt); else pass_cnt++;
   endtask

   task automatic test_odd_height();
      fill_random();
      out_cnt = 0;
      send_frame(4, 3, 2, 1'b1, -1);
      drain();
      total_cnt += 2;
      if (out_cnt != 2) $display("FAIL odd_height_count: got %0d want 2", out_cnt); else pass_cnt++;
      if (o_err !== 1'b0) $display("FAIL odd_height_err: got %b want 0", o_err); else pass_cnt++;
   endtask

   task automatic test_odd_width();
      fill_random();
      out_cnt = 0;
      send_frame(5, 4, 0, 1'b1, -1);
      drain();
      total_cnt += 2;
      if (out_cnt != 4) $display("FAIL odd_width_count: got %0d want 4", out_cnt); else pass_cnt++;
      if (o_err !== 1'b1) $display("FAIL odd_width_err: got %b want 1", o_err); else pass_cnt++;
      do_reset();
      @(negedge clk);
      total_cnt++;
      if (o_err !== 1'b0) $display("FAIL odd_width_err_clear: got %b want 0", o_err); else pass_cnt++;
   endtask

   task automatic test_too_wide();
      fill_random();
      out_cnt = 0;
      send_frame(MAX_W + 2, 2, 0, 1'b1, -1);
      drain();
      total_cnt += 2;
      if (out_cnt != MAX_W / 2) $display("FAIL wide_count: got %0d want %0d", out_cnt, MAX_W / 2); else pass_cnt++;
      if (o_err !== 1'b1) $display("FAIL wide_err: got %b want 1", o_err); else pass_cnt++;
      do_reset();
   endtask

   task automatic test_one_pixel_line();
      fill_random();
      sb_en = 1'b0;
      out_cnt = 0;
      send_frame(1, 1, 0, 1'b1, -1);
      send_frame(4, 1, 0, 1'b0, -1);
      drain();
      total_cnt += 2;
      if (out_cnt != 2) $display("FAIL one_px_odd_row_count: got %0d want 2", out_cnt); else pass_cnt++;
      if (o_err !== 1'b1) $display("FAIL one_px_err: got %b want 1", o_err); else pass_cnt++;
      sb_en = 1'b1;
      do_reset();
   endtask

   task automatic test_reset_mid_frame();
      fill_basic();
      send_frame(4, 2, 0, 1'b1, 7);
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      due_q.delete();
      err_due = NEVER;
      @(posedge clk);
      @(negedge clk);
      total_cnt += 3;
      if (o_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", o_valid); else pass_cnt++;
      if (o_data !== '0)    $display("FAIL mid_rst_data: got %h want 0", o_data);   else pass_cnt++;
      if (o_err !== 1'b0)   $display("FAIL mid_rst_err: got %b want 0", o_err);     else pass_cnt++;
      @(posedge clk); #1;
      rst = 1'b0;
      out_cnt = 0;
      send_frame(4, 2, 0, 1'b0, -1);
      drain();
      total_cnt++;
      if (out_cnt != 0) $display("FAIL no_sof_count: got %0d want 0", out_cnt); else pass_cnt++;
      send_frame(4, 2, 0, 1'b1, -1);
      drain();
      total_cnt += 2;
      if (out_cnt != 2) $display("FAIL after_rst_count: got %0d want 2", out_cnt); else pass_cnt++;
      if (o_data[7:0] !== SECOND_CH0)
         $display("FAIL after_rst_ch0: got %0d want %0d", o_data[7:0], SECOND_CH0);
      else pass_cnt++;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish by 1000000, want earlier finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_all_max();
      test_gaps();
      test_odd_height();
      test_odd_width();
      test_too_wide();
      test_one_pixel_line();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
